// File: rtl/scan_fwd_if.sv
// Storage/PE-side bundle of the SCAN read-after-write forwarding unit.
// The master drives the storage read/write traffic; the slave returns the merged read data.
interface scan_fwd_if #(
    parameter int unsigned P   = 256,
    parameter int unsigned Q   = 6,
    parameter int unsigned AW  = 8,
    parameter int unsigned NRD = 4,
    parameter int unsigned CW  = 16
);
    logic                 flush;
    logic                 wr_valid;
    logic [AW-1:0]        wr_addr;
    logic [P-1:0]         wr_mask;
    logic [P*Q-1:0]       wr_data;
    logic [NRD-1:0]       rd_valid;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*P*Q-1:0]   mem_data;
    logic [NRD*P*Q-1:0]   rd_data_o;
    logic [NRD-1:0]       rd_vld_o;
    logic [NRD-1:0]       fwd_hit_o;
    logic [CW-1:0]        hit_cnt_o;

    modport master (
        output flush, wr_valid, wr_addr, wr_mask, wr_data, rd_valid, rd_addr, mem_data,
        input  rd_data_o, rd_vld_o, fwd_hit_o, hit_cnt_o
    );

    modport slave (
        input  flush, wr_valid, wr_addr, wr_mask, wr_data, rd_valid, rd_addr, mem_data,
        output rd_data_o, rd_vld_o, fwd_hit_o, hit_cnt_o
    );
endinterface

// File: rtl/scan_fwd_unit.sv
// Read-after-write forwarding for the SCAN LLR storage: merges PE writes that
// storage has not yet reflected over the read data, newest lane write wins.
module scan_fwd_unit #(
    parameter int unsigned P      = 256,
    parameter int unsigned Q      = 6,
    parameter int unsigned AW     = 8,
    parameter int unsigned NRD    = 4,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned CW     = 16
) (
    input  logic       clk,
    input  logic       rst,
    scan_fwd_if.slave  bus
);
    localparam int unsigned W  = P * Q;
    localparam int unsigned SW = CW + 1;

    // Write history, entry 0 is the newest (previous cycle)
    logic [RD_LAT-1:0]               hv_q, hv_d;
    logic [RD_LAT-1:0][AW-1:0]       ha_q;
    logic [RD_LAT-1:0][P-1:0]        hm_q;
    logic [RD_LAT-1:0][W-1:0]        hd_q;

    // Read-issue delay line, last stage lines up with mem_data
    logic [RD_LAT-1:0][NRD-1:0]      pv_q, pv_d;
    logic [RD_LAT-1:0][NRD*AW-1:0]   pa_q;

    logic [NRD-1:0]                  arr_vld_c;
    logic [NRD*AW-1:0]               arr_addr_c;
    logic [NRD*W-1:0]                merged_c;
    logic [NRD-1:0]                  hit_c;

    logic [NRD*W-1:0]                rd_data_q, rd_data_d;
    logic [NRD-1:0]                  rd_vld_q;
    logic [NRD-1:0]                  fwd_hit_q, fwd_hit_d;
    logic [CW-1:0]                   hit_cnt_q, hit_cnt_d;
    logic [SW-1:0]                   sum_c;

    assign arr_vld_c  = pv_q[RD_LAT-1];
    assign arr_addr_c = pa_q[RD_LAT-1];

    always_comb begin : shift_next
        hv_d[0] = bus.wr_valid & ~bus.flush;
        pv_d[0] = bus.rd_valid;
        for (int j = 1; j < int'(RD_LAT); j++) begin
            hv_d[j] = hv_q[j-1] & ~bus.flush;
            pv_d[j] = pv_q[j-1];
        end
    end

    // Payload fields are qualified by the valid bits and need no reset
    always_ff @(posedge clk) begin : shift_payload
        ha_q[0] <= bus.wr_addr;
        hm_q[0] <= bus.wr_mask;
        hd_q[0] <= bus.wr_data;
        pa_q[0] <= bus.rd_addr;
        for (int j = 1; j < int'(RD_LAT); j++) begin
            ha_q[j] <= ha_q[j-1];
            hm_q[j] <= hm_q[j-1];
            hd_q[j] <= hd_q[j-1];
            pa_q[j] <= pa_q[j-1];
        end
    end

    // Oldest history entry first, live write last, so later writes overwrite earlier ones
    always_comb begin : merge
        merged_c = bus.mem_data;
        hit_c    = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            for (int j = int'(RD_LAT) - 1; j >= 0; j--) begin
                if (hv_q[j] && (ha_q[j] == arr_addr_c[k*AW +: AW])) begin
                    for (int i = 0; i < int'(P); i++) begin
                        if (hm_q[j][i]) begin
                            merged_c[(k*int'(P) + i)*int'(Q) +: Q] = hd_q[j][i*int'(Q) +: Q];
                            hit_c[k] = 1'b1;
                        end
                    end
                end
            end
            if (bus.wr_valid && (bus.wr_addr == arr_addr_c[k*AW +: AW])) begin
                for (int i = 0; i < int'(P); i++) begin
                    if (bus.wr_mask[i]) begin
                        merged_c[(k*int'(P) + i)*int'(Q) +: Q] = bus.wr_data[i*int'(Q) +: Q];
                        hit_c[k] = 1'b1;
                    end
                end
            end
        end
        fwd_hit_d = hit_c & arr_vld_c;
    end

    always_comb begin : out_next
        rd_data_d = rd_data_q;
        for (int k = 0; k < int'(NRD); k++) begin
            if (arr_vld_c[k]) begin
                rd_data_d[k*W +: W] = merged_c[k*W +: W];
            end
        end
        sum_c = SW'(hit_cnt_q);
        for (int k = 0; k < int'(NRD); k++) begin
            sum_c = sum_c + SW'(fwd_hit_d[k]);
        end
        hit_cnt_d = sum_c[CW] ? {CW{1'b1}} : sum_c[CW-1:0];
    end

    always_ff @(posedge clk) begin : ctrl_regs
        if (rst) begin
            hv_q      <= '0;
            pv_q      <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= '0;
            fwd_hit_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            hv_q      <= hv_d;
            pv_q      <= pv_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= arr_vld_c;
            fwd_hit_q <= fwd_hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.rd_vld_o  = rd_vld_q;
    assign bus.fwd_hit_o = fwd_hit_q;
    assign bus.hit_cnt_o = hit_cnt_q;
endmodule
